// File: rtl/axi_pkg.sv
// Shared AXI read-channel types: burst/response encodings, responder states and
// the per-beat address stepping rule (FIXED / INCR / WRAP).
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        BURST
    } state_e;

    // WRAP keeps the bits above the wrap window and steps only inside it.
    function automatic logic [63:0] next_beat_addr(input logic [63:0] addr,
                                                   input logic [2:0]  size,
                                                   input logic [7:0]  len,
                                                   input logic [1:0]  burst);
        logic [63:0] step;
        logic [63:0] wrap_mask;
        logic [63:0] result;
        step      = 64'd1 << size;
        wrap_mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
        case (burst)
            BURST_INCR: result = addr + step;
            BURST_WRAP: result = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:    result = addr;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/axi_rd_responder_if.sv
// AR/R channel bundle between a read master and the read responder.
interface axi_rd_responder_if #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_addr_gen.sv
// Combinational beat-address stepping and error classification for one AXI burst;
// shared between the read and (future) write responders.
module axi_rd_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int MEM_WORDS  = 4096
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  cfg_err,
    output logic                  range_err
);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS) << 3;

    logic [ADDR_WIDTH-1:0] size_mask;

    assign next_addr = ADDR_WIDTH'(next_beat_addr(64'(addr), size, len, burst));
    assign range_err = (addr >= MEM_BYTES);
    assign size_mask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);

    // Stepping preserves the low address bits, so checking any beat's alignment
    // gives the same answer as checking the start address.
    always_comb begin
        cfg_err = 1'b0;
        if (burst == BURST_RSVD) cfg_err = 1'b1;
        if (size > 3'd3) cfg_err = 1'b1;
        if (burst == BURST_WRAP) begin
            if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) cfg_err = 1'b1;
            if ((addr & size_mask) != '0) cfg_err = 1'b1;
        end
    end
endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder over a 64-bit word memory with a backdoor preload port.
// Define AXI_RD_RESP_LAT_EN to insert LATENCY idle cycles before the first beat.
module axi_rd_responder
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 4096,
    parameter int LATENCY    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    axi_rd_responder_if.slave            s_axi,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata
);
    localparam int IDX_W = $clog2(MEM_WORDS);
`ifdef AXI_RD_RESP_LAT_EN
    localparam int DELAY_CYCLES = LATENCY;
`else
    localparam int DELAY_CYCLES = 0;
`endif
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_e                state, state_n;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q, beat_cnt;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [CNT_W-1:0]      delay_cnt;

    logic                  in_idle, ar_hs, r_hs, load_beat, beat_last, beat_err;
    logic [ADDR_WIDTH-1:0] g_addr, next_addr;
    logic [7:0]            g_len;
    logic [2:0]            g_size;
    logic [1:0]            g_burst;
    logic                  cfg_err, range_err;

    // In IDLE the first beat comes straight off the AR bus; afterwards from the latched request.
    assign in_idle   = (state == IDLE);
    assign ar_hs     = s_axi.arvalid && arready_q;
    assign r_hs      = rvalid_q && s_axi.rready;
    assign g_addr    = in_idle ? s_axi.araddr  : addr_q;
    assign g_len     = in_idle ? s_axi.arlen   : len_q;
    assign g_size    = in_idle ? s_axi.arsize  : size_q;
    assign g_burst   = in_idle ? s_axi.arburst : burst_q;
    assign beat_last = (g_len == (in_idle ? 8'd0 : beat_cnt));
    assign beat_err  = cfg_err || range_err;

    axi_rd_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_addr_gen (
        .addr      (g_addr),
        .size      (g_size),
        .len       (g_len),
        .burst     (g_burst),
        .next_addr (next_addr),
        .cfg_err   (cfg_err),
        .range_err (range_err)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        load_beat = 1'b0;
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    if (DELAY_CYCLES != 0) begin
                        state_n = DELAY;
                    end else begin
                        state_n   = BURST;
                        load_beat = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (delay_cnt == '0) begin
                    state_n   = BURST;
                    load_beat = 1'b1;
                end
            end
            BURST: begin
                if (r_hs) begin
                    if (rlast_q) state_n = IDLE;
                    else         load_beat = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A beat load reads mem before any same-edge backdoor write lands, so it sees old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_cnt  <= '0;
            delay_cnt <= '0;
        end else begin
            arready_q <= (state_n == IDLE);
            if (ar_hs) begin
                rid_q     <= s_axi.arid;
                addr_q    <= s_axi.araddr;
                len_q     <= s_axi.arlen;
                size_q    <= s_axi.arsize;
                burst_q   <= s_axi.arburst;
                beat_cnt  <= '0;
                delay_cnt <= CNT_W'(DELAY_CYCLES - 1);
            end else if (state == DELAY) begin
                delay_cnt <= delay_cnt - CNT_W'(1);
            end
            if (load_beat) begin
                rvalid_q <= 1'b1;
                rlast_q  <= beat_last;
                rdata_q  <= beat_err ? '0 : mem[g_addr[3 +: IDX_W]];
                rresp_q  <= beat_err ? RESP_SLVERR : RESP_OKAY;
                addr_q   <= next_addr;
                beat_cnt <= (in_idle ? 8'd0 : beat_cnt) + 8'd1;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    // Contents survive reset so a preloaded image outlives a mid-burst reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: directed and random bursts checked against an
// arithmetic model of the beat addresses, error rules and memory contents.
module tb_axi_rd_responder;
    localparam int ID_WIDTH   = 13;
    localparam int ADDR_WIDTH = 64;
    localparam int DATA_WIDTH = 64;
    localparam int MEM_WORDS  = 4096;
    localparam int LATENCY    = 4;
`ifdef AXI_RD_RESP_LAT_EN
    localparam int EXP_LAT = (LATENCY == 0) ? 1 : LATENCY + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        mem_we    = 1'b0;
    logic [11:0] mem_waddr = '0;
    logic [63:0] mem_wdata = '0;
    logic [63:0] ref_mem [MEM_WORDS];
    int          vectors     = 0;
    int          miscompares = 0;

    axi_rd_responder_if #(
        .ID_WIDTH   (ID_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) s_axi ();

    axi_rd_responder #(
        .ID_WIDTH   (ID_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .LATENCY    (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_axi     (s_axi),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic backdoor_write(input int idx, input logic [63:0] data);
        mem_we    = 1'b1;
        mem_waddr = 12'(idx);
        mem_wdata = data;
        tick();
        mem_we       = 1'b0;
        ref_mem[idx] = data;
    endtask

    // Beat i address from the burst rules directly, not by stepping beat to beat.
    function automatic void expect_beat(input logic [63:0] start, input int len, input int size,
                                        input int burst, input int i,
                                        output logic [63:0] data, output logic [1:0] resp);
        longint unsigned step, wrap, base, a;
        bit bad;
        step = 64'd1 << size;
        wrap = 64'(len + 1) * step;
        bad  = (burst == 3) || (size > 3);
        if (burst == 2) bad = bad || !(len inside {1, 3, 7, 15}) || ((start % step) != 0);
        case (burst)
            0:       a = start;
            2: begin
                base = start - (start % wrap);
                a    = base + ((start - base + 64'(i) * step) % wrap);
            end
            default: a = start + 64'(i) * step;
        endcase
        if (bad || a >= 64'(MEM_WORDS * 8)) begin
            data = '0;
            resp = 2'b10;
        end else begin
            data = ref_mem[int'(a >> 3)];
            resp = 2'b00;
        end
    endfunction

    task automatic check_beat(input string tag, input logic [12:0] id, input logic [63:0] data,
                              input logic [1:0] resp, input logic last);
        check_output({tag, "_rvalid"}, 64'(s_axi.rvalid), 64'd1);
        check_output({tag, "_rid"},    64'(s_axi.rid),    64'(id));
        check_output({tag, "_rdata"},  s_axi.rdata,       data);
        check_output({tag, "_rresp"},  64'(s_axi.rresp),  64'(resp));
        check_output({tag, "_rlast"},  64'(s_axi.rlast),  64'(last));
    endtask

    task automatic apply_stimulus(input logic [12:0] id, input logic [63:0] addr, input int len,
                                  input int size, input int burst, input int stall_beat,
                                  input int stall_cycles, input int abort_beat);
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
        int          lat;
        bit          got;
        s_axi.arid    = id;
        s_axi.araddr  = addr;
        s_axi.arlen   = 8'(len);
        s_axi.arsize  = 3'(size);
        s_axi.arburst = 2'(burst);
        s_axi.arvalid = 1'b1;
        s_axi.rready  = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (s_axi.arready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check_output("ar_accept", 64'(got), 64'd1);
        if (!got) begin
            s_axi.arvalid = 1'b0;
            return;
        end
        tick();
        s_axi.arvalid = 1'b0;
        check_output("arready_busy", 64'(s_axi.arready), 64'd0);
        lat = 1;
        while (!s_axi.rvalid && lat < 20) begin
            tick();
            lat++;
        end
        check_output("first_beat_latency", 64'(lat), 64'(EXP_LAT));
        for (int i = 0; i <= len; i++) begin
            expect_beat(addr, len, size, burst, i, exp_data, exp_resp);
            if (i == stall_beat) begin
                s_axi.rready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    check_beat($sformatf("stall%0d_beat%0d", s, i), id, exp_data, exp_resp, i == len);
                    tick();
                end
                s_axi.rready = 1'b1;
            end
            check_beat($sformatf("beat%0d", i), id, exp_data, exp_resp, i == len);
            if (i == abort_beat) begin
                reset = 1'b1;
                tick();
                check_output("abort_rvalid", 64'(s_axi.rvalid), 64'd0);
                check_output("abort_rlast",  64'(s_axi.rlast),  64'd0);
                reset = 1'b0;
                tick();
                check_output("abort_arready", 64'(s_axi.arready), 64'd1);
                return;
            end
            tick();
        end
        check_output("post_burst_rvalid",  64'(s_axi.rvalid),  64'd0);
        check_output("post_burst_arready", 64'(s_axi.arready), 64'd1);
    endtask

    initial begin
        s_axi.arid    = '0;
        s_axi.araddr  = '0;
        s_axi.arlen   = '0;
        s_axi.arsize  = '0;
        s_axi.arburst = '0;
        s_axi.arvalid = 1'b0;
        s_axi.rready  = 1'b0;

        // Reset values, then arready one edge after release.
        repeat (3) tick();
        check_output("reset_arready", 64'(s_axi.arready), 64'd0);
        check_output("reset_rvalid",  64'(s_axi.rvalid),  64'd0);
        check_output("reset_rlast",   64'(s_axi.rlast),   64'd0);
        check_output("reset_rdata",   s_axi.rdata,        64'd0);
        check_output("reset_rresp",   64'(s_axi.rresp),   64'd0);
        check_output("reset_rid",     64'(s_axi.rid),     64'd0);
        reset = 1'b0;
        tick();
        check_output("arready_after_reset", 64'(s_axi.arready), 64'd1);

        for (int i = 0; i < MEM_WORDS; i++) backdoor_write(i, 64'h1000 + 64'(i));

        apply_stimulus(13'd5, 64'h38, 7, 3, 2, -1, 0, -1);
        apply_stimulus(13'd3, 64'h10, 3, 3, 1, -1, 0, -1);
        apply_stimulus(13'd4, 64'h10, 3, 3, 1, 1, 3, -1);
        apply_stimulus(13'd6, 64'(MEM_WORDS * 8 - 8), 1, 3, 1, -1, 0, -1);
        apply_stimulus(13'd7, 64'h80, 3, 3, 3, -1, 0, -1);
        apply_stimulus(13'd8, 64'h3C, 3, 3, 2, -1, 0, -1);
        apply_stimulus(13'd8, 64'h40, 2, 3, 2, -1, 0, -1);
        apply_stimulus(13'd1, 64'h40, 2, 4, 1, -1, 0, -1);
        apply_stimulus(13'd2, 64'h100, 3, 3, 0, 2, 1, -1);
        apply_stimulus(13'd2, 64'h4, 5, 2, 1, -1, 0, -1);
        apply_stimulus(13'd2, 64'h18, 3, 2, 2, -1, 0, -1);

        apply_stimulus(13'd9, 64'h20, 7, 3, 2, -1, 0, 2);
        apply_stimulus(13'd10, 64'h40, 3, 3, 1, -1, 0, -1);

        backdoor_write(0, 64'd0);
        apply_stimulus(13'd11, 64'h0, 0, 3, 1, -1, 0, -1);

        for (int n = 0; n < 24; n++) begin
            int          len, size, burst;
            logic [63:0] addr;
            burst = int'($urandom_range(0, 3));
            size  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            if (burst == 2) begin
                case ($urandom_range(0, 4))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    3: len = 15;
                    default: len = 2;
                endcase
            end else begin
                len = int'($urandom_range(0, 20));
            end
            addr = 64'($urandom_range(0, MEM_WORDS * 8 - 1));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
            if ($urandom_range(0, 1) == 1)
                backdoor_write(int'($urandom_range(0, MEM_WORDS - 1)), {$urandom, $urandom});
            apply_stimulus(13'($urandom), addr, len, size, burst,
                           int'($urandom_range(0, len)), int'($urandom_range(0, 2)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
